// File: rtl/vector_alu_sequencer.sv
// Registered multi-beat ALU control sequencer: decodes one instruction per handshake
// and issues scalar (1 beat) or vector (BEATS beats) ALU control. Optional macro: VEC_SHIFT_EN.
module vector_alu_sequencer #(
  parameter int LANES           = 16,
  parameter int LANES_PER_CYCLE = 4,
  localparam int BEATS          = LANES / LANES_PER_CYCLE,
  localparam int BW             = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       Opcode,
  input  logic [2:0]       Func,
  input  logic             ALUOp,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [2:0]       ALUControl,
  output logic             ALUSel,
  output logic [1:0]       FlagWrite,
  output logic [LANES-1:0] lane_en,
  output logic [BW-1:0]    beat_idx,
  output logic             op_last,
  output logic             busy,
  output logic             illegal
);

  if ((LANES % LANES_PER_CYCLE) != 0) begin : g_cfg_err
    $error("LANES must be a multiple of LANES_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SCALAR = 2'd1, VECTOR = 2'd2} state_t;

  localparam logic [LANES-1:0] FIRST_MASK = ~({LANES{1'b1}} << LANES_PER_CYCLE);
  localparam logic [BW-1:0]    LAST_BEAT  = BW'(BEATS - 1);

  // Returns {legal, vector, alu_control}
  function automatic logic [4:0] decode(input logic [5:0] opc, input logic [2:0] fn,
                                        input logic aluop);
    logic [4:0] r;
    r = {1'b1, 1'b0, 3'b000};
    if (!aluop) begin
      r = {1'b1, 1'b0, 3'b000};
    end else begin
      case (opc)
        6'b000000: begin
          case (fn)
            3'b000:  r = {1'b1, 1'b0, 3'b000};
            3'b001:  r = {1'b1, 1'b0, 3'b001};
            3'b010:  r = {1'b1, 1'b0, 3'b010};
            3'b011:  r = {1'b1, 1'b0, 3'b011};
            3'b100:  r = {1'b1, 1'b0, 3'b111};
            default: r = {1'b0, 1'b0, 3'b000};
          endcase
        end
        6'b100000: begin
          case (fn)
            3'b000:  r = {1'b1, 1'b1, 3'b000};
            3'b001:  r = {1'b1, 1'b1, 3'b001};
            3'b010:  r = {1'b1, 1'b1, 3'b010};
`ifdef VEC_SHIFT_EN
            3'b011:  r = {1'b1, 1'b1, 3'b011};
            3'b100:  r = {1'b1, 1'b1, 3'b111};
`endif
            default: r = {1'b0, 1'b0, 3'b000};
          endcase
        end
        6'b001000: r = {1'b1, 1'b0, 3'b000};
        6'b001001: r = {1'b1, 1'b0, 3'b001};
        6'b001010: r = {1'b1, 1'b0, 3'b010};
        6'b000100: r = {1'b1, 1'b0, 3'b001};
        default:   r = {1'b1, 1'b0, 3'b000};
      endcase
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic             valid_r, valid_s;
  logic [2:0]       ctrl_r, ctrl_s;
  logic [1:0]       flag_r, flag_s;
  logic [LANES-1:0] lane_r, lane_s;
  logic [BW-1:0]    beat_r, beat_s;
  logic             last_r, last_s;
  logic             illegal_r, illegal_s;

  logic [4:0]       dec_s;
  logic             in_ready_s, accept_s, advance_s;
  state_t           ld_state_s;
  logic             ld_valid_s, ld_last_s, ld_illegal_s;
  logic [2:0]       ld_ctrl_s;
  logic [1:0]       ld_flag_s;
  logic [LANES-1:0] ld_lane_s;

  assign dec_s      = decode(Opcode, Func, ALUOp);
  assign in_ready_s = !flush & ((state_r == IDLE) | (valid_r & op_ready & last_r));
  assign accept_s   = in_valid & in_ready_s;
  assign advance_s  = valid_r & op_ready;

  // First-beat image of the instruction currently offered on the input
  always_comb begin
    ld_state_s   = IDLE;
    ld_valid_s   = 1'b0;
    ld_ctrl_s    = 3'b000;
    ld_flag_s    = 2'b00;
    ld_lane_s    = {LANES{1'b0}};
    ld_last_s    = 1'b0;
    ld_illegal_s = 1'b0;
    if (!dec_s[4]) begin
      ld_illegal_s = 1'b1;
    end else if (dec_s[3]) begin
      ld_state_s = VECTOR;
      ld_valid_s = 1'b1;
      ld_ctrl_s  = dec_s[2:0];
      ld_lane_s  = FIRST_MASK;
      ld_last_s  = (BEATS == 1);
    end else begin
      ld_state_s = SCALAR;
      ld_valid_s = 1'b1;
      ld_ctrl_s  = dec_s[2:0];
      ld_flag_s  = 2'b11;
      ld_lane_s  = LANES'(1'b1);
      ld_last_s  = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s   = state_r;
    valid_s   = valid_r;
    ctrl_s    = ctrl_r;
    flag_s    = flag_r;
    lane_s    = lane_r;
    beat_s    = beat_r;
    last_s    = last_r;
    illegal_s = 1'b0;
    if (flush) begin
      state_s = IDLE;
      valid_s = 1'b0;
      ctrl_s  = 3'b000;
      flag_s  = 2'b00;
      lane_s  = {LANES{1'b0}};
      beat_s  = {BW{1'b0}};
      last_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s   = ld_state_s;
            valid_s   = ld_valid_s;
            ctrl_s    = ld_ctrl_s;
            flag_s    = ld_flag_s;
            lane_s    = ld_lane_s;
            beat_s    = {BW{1'b0}};
            last_s    = ld_last_s;
            illegal_s = ld_illegal_s;
          end else begin
            state_s = IDLE;
          end
        end
        SCALAR, VECTOR: begin
          if (advance_s && last_r) begin
            // accept_s already implies in_ready, so a new op can follow without a bubble
            state_s   = accept_s ? ld_state_s : IDLE;
            valid_s   = accept_s & ld_valid_s;
            ctrl_s    = accept_s ? ld_ctrl_s : 3'b000;
            flag_s    = accept_s ? ld_flag_s : 2'b00;
            lane_s    = accept_s ? ld_lane_s : {LANES{1'b0}};
            beat_s    = {BW{1'b0}};
            last_s    = accept_s & ld_last_s;
            illegal_s = accept_s & ld_illegal_s;
          end else if (advance_s) begin
            beat_s = beat_r + BW'(1'b1);
            lane_s = lane_r << LANES_PER_CYCLE;
            last_s = ((beat_r + BW'(1'b1)) == LAST_BEAT);
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s = IDLE;
          valid_s = 1'b0;
          ctrl_s  = 3'b000;
          flag_s  = 2'b00;
          lane_s  = {LANES{1'b0}};
          beat_s  = {BW{1'b0}};
          last_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      valid_r   <= 1'b0;
      ctrl_r    <= 3'b000;
      flag_r    <= 2'b00;
      lane_r    <= {LANES{1'b0}};
      beat_r    <= {BW{1'b0}};
      last_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      valid_r   <= valid_s;
      ctrl_r    <= ctrl_s;
      flag_r    <= flag_s;
      lane_r    <= lane_s;
      beat_r    <= beat_s;
      last_r    <= last_s;
      illegal_r <= illegal_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign op_valid   = valid_r;
  assign ALUControl = ctrl_r;
  assign ALUSel     = 1'b0;
  assign FlagWrite  = flag_r;
  assign lane_en    = lane_r;
  assign beat_idx   = beat_r;
  assign op_last    = last_r;
  assign busy       = (state_r != IDLE);
  assign illegal    = illegal_r;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Self-checking bench for vector_alu_sequencer: decode table, directed corner
// sequences and randomized traffic checked against a beat-queue reference model.
module tb_vector_alu_sequencer;
  localparam int LANES = 16;
  localparam int LPC   = 4;
  localparam int BEATS = LANES / LPC;
  localparam int BW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0, in_valid = 1'b0, op_ready = 1'b0, ALUOp = 1'b0;
  logic [5:0]       Opcode = 6'd0;
  logic [2:0]       Func = 3'd0;
  logic             in_ready, op_valid, ALUSel, op_last, busy, illegal;
  logic [2:0]       ALUControl;
  logic [1:0]       FlagWrite;
  logic [LANES-1:0] lane_en;
  logic [BW-1:0]    beat_idx;

  vector_alu_sequencer #(.LANES(LANES), .LANES_PER_CYCLE(LPC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Opcode(Opcode), .Func(Func), .ALUOp(ALUOp), .op_valid(op_valid), .op_ready(op_ready),
    .ALUControl(ALUControl), .ALUSel(ALUSel), .FlagWrite(FlagWrite), .lane_en(lane_en),
    .beat_idx(beat_idx), .op_last(op_last), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       ctrl;
    logic [1:0]       flag;
    logic [LANES-1:0] lane;
    logic [BW-1:0]    beat;
    logic             last;
  } beat_t;

  typedef struct {
    logic [5:0] opc;
    logic [2:0] fn;
    logic       al;
    logic       legal;
    logic [2:0] ctrl;
    int         beats;
  } tv_t;

  beat_t exp_q[$];
  logic  exp_ill = 1'b0;
  int    nerr = 0;
  int    nchk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode rules written straight from the instruction table
  function automatic void ref_decode(input logic [5:0] opc, input logic [2:0] fn, input logic al,
                                     output logic legal, output logic vec, output logic [2:0] ctrl);
    legal = 1'b1; vec = 1'b0; ctrl = 3'b000;
    if (al) begin
      if (opc == 6'b000000) begin
        if (fn <= 3'd3) ctrl = fn;
        else if (fn == 3'd4) ctrl = 3'b111;
        else legal = 1'b0;
      end else if (opc == 6'b100000) begin
        vec = 1'b1;
        if (fn <= 3'd2) ctrl = fn;
`ifdef VEC_SHIFT_EN
        else if (fn == 3'd3) ctrl = 3'b011;
        else if (fn == 3'd4) ctrl = 3'b111;
`endif
        else begin legal = 1'b0; vec = 1'b0; end
      end else if (opc == 6'b001001 || opc == 6'b000100) ctrl = 3'b001;
      else if (opc == 6'b001010) ctrl = 3'b010;
      else ctrl = 3'b000;
    end
  endfunction

  task automatic post_check();
    logic act;
    act = (exp_q.size() > 0);
    chk("op_valid", op_valid, act);
    chk("busy", busy, act);
    chk("illegal", illegal, exp_ill);
    chk("ALUSel", ALUSel, 1'b0);
    if (act) begin
      chk("ALUControl", ALUControl, exp_q[0].ctrl);
      chk("FlagWrite", FlagWrite, exp_q[0].flag);
      chk("lane_en", lane_en, exp_q[0].lane);
      chk("beat_idx", beat_idx, exp_q[0].beat);
      chk("op_last", op_last, exp_q[0].last);
    end
  endtask

  // One clock cycle: drive, check in_ready, advance the model, check outputs after the edge
  task automatic step(input logic v, input logic [5:0] opc, input logic [2:0] fn,
                      input logic al, input logic rdy, input logic fl);
    logic exp_rdy, legal, vec;
    logic [2:0] c;
    beat_t b;
    in_valid = v; Opcode = opc; Func = fn; ALUOp = al; op_ready = rdy; flush = fl;
    #1;
    exp_rdy = !fl && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
    chk("in_ready", in_ready, exp_rdy);
    exp_ill = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (v && exp_rdy) begin
        ref_decode(opc, fn, al, legal, vec, c);
        if (!legal) begin
          exp_ill = 1'b1;
        end else if (!vec) begin
          b.ctrl = c; b.flag = 2'b11; b.lane = LANES'(1); b.beat = '0; b.last = 1'b1;
          exp_q.push_back(b);
        end else begin
          for (int k = 0; k < BEATS; k++) begin
            b.ctrl = c; b.flag = 2'b00;
            for (int l = 0; l < LANES; l++) b.lane[l] = ((l / LPC) == k);
            b.beat = BW'(k); b.last = (k == BEATS - 1);
            exp_q.push_back(b);
          end
        end
      end
    end
    @(posedge clk); #1;
    post_check();
  endtask

  task automatic idle_cycle();
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  tv_t tbl[$];

  initial begin
    tv_t t;
    int cnt;
    tbl.push_back('{6'b100000, 3'b111, 1'b0, 1'b1, 3'b000, 1});
    tbl.push_back('{6'b000000, 3'b000, 1'b1, 1'b1, 3'b000, 1});
    tbl.push_back('{6'b000000, 3'b001, 1'b1, 1'b1, 3'b001, 1});
    tbl.push_back('{6'b000000, 3'b010, 1'b1, 1'b1, 3'b010, 1});
    tbl.push_back('{6'b000000, 3'b011, 1'b1, 1'b1, 3'b011, 1});
    tbl.push_back('{6'b000000, 3'b100, 1'b1, 1'b1, 3'b111, 1});
    tbl.push_back('{6'b000000, 3'b101, 1'b1, 1'b0, 3'b000, 0});
    tbl.push_back('{6'b000000, 3'b111, 1'b1, 1'b0, 3'b000, 0});
    tbl.push_back('{6'b100000, 3'b000, 1'b1, 1'b1, 3'b000, 4});
    tbl.push_back('{6'b100000, 3'b001, 1'b1, 1'b1, 3'b001, 4});
    tbl.push_back('{6'b100000, 3'b010, 1'b1, 1'b1, 3'b010, 4});
`ifdef VEC_SHIFT_EN
    tbl.push_back('{6'b100000, 3'b011, 1'b1, 1'b1, 3'b011, 4});
    tbl.push_back('{6'b100000, 3'b100, 1'b1, 1'b1, 3'b111, 4});
`else
    tbl.push_back('{6'b100000, 3'b011, 1'b1, 1'b0, 3'b000, 0});
    tbl.push_back('{6'b100000, 3'b100, 1'b1, 1'b0, 3'b000, 0});
`endif
    tbl.push_back('{6'b100000, 3'b110, 1'b1, 1'b0, 3'b000, 0});
    tbl.push_back('{6'b001000, 3'b101, 1'b1, 1'b1, 3'b000, 1});
    tbl.push_back('{6'b001001, 3'b000, 1'b1, 1'b1, 3'b001, 1});
    tbl.push_back('{6'b001010, 3'b000, 1'b1, 1'b1, 3'b010, 1});
    tbl.push_back('{6'b000100, 3'b000, 1'b1, 1'b1, 3'b001, 1});
    tbl.push_back('{6'b111111, 3'b010, 1'b1, 1'b1, 3'b000, 1});
    tbl.push_back('{6'b001011, 3'b000, 1'b1, 1'b1, 3'b000, 1});

    // reset values, before any clock edge
    #2;
    chk("rst op_valid", op_valid, 1'b0);
    chk("rst ALUControl", ALUControl, 3'b000);
    chk("rst FlagWrite", FlagWrite, 2'b00);
    chk("rst lane_en", lane_en, 16'h0000);
    chk("rst beat_idx", beat_idx, 2'd0);
    chk("rst op_last", op_last, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst illegal", illegal, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // decode table: each entry issued alone from idle, beats counted
    foreach (tbl[i]) begin
      t = tbl[i];
      step(1'b1, t.opc, t.fn, t.al, 1'b1, 1'b0);
      chk($sformatf("tbl%0d illegal", i), illegal, !t.legal);
      if (t.legal) chk($sformatf("tbl%0d ctrl", i), ALUControl, t.ctrl);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
        if (!op_valid) break;
        cnt++;
        idle_cycle();
      end
      chk($sformatf("tbl%0d beats", i), cnt, t.beats);
    end

    // scalar add: single beat, flags written, lane 0
    step(1'b1, 6'b000000, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("add lane_en", lane_en, 16'h0001);
    chk("add FlagWrite", FlagWrite, 2'b11);
    chk("add op_last", op_last, 1'b1);
    idle_cycle();

    // mulv with a 3-cycle stall in beat 1
    step(1'b1, 6'b100000, 3'b010, 1'b1, 1'b1, 1'b0);
    chk("mulv b0 lane", lane_en, 16'h000F);
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk("stall beat_idx", beat_idx, 2'd1);
      chk("stall lane_en", lane_en, 16'h00F0);
      chk("stall op_last", op_last, 1'b0);
    end
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("mulv b2 lane", lane_en, 16'h0F00);
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("mulv b3 lane", lane_en, 16'hF000);
    chk("mulv b3 last", op_last, 1'b1);
    chk("mulv b3 flag", FlagWrite, 2'b00);
    idle_cycle();

    // flush during beat 2 with a same-cycle instruction offered
    step(1'b1, 6'b100000, 3'b001, 1'b1, 1'b1, 1'b0);
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("pre-flush beat", beat_idx, 2'd2);
    step(1'b1, 6'b001001, 3'b000, 1'b1, 1'b1, 1'b1);
    chk("flush lane_en", lane_en, 16'h0000);
    chk("flush ALUControl", ALUControl, 3'b000);
    chk("flush beat_idx", beat_idx, 2'd0);
    chk("flush FlagWrite", FlagWrite, 2'b00);
    idle_cycle();

    // asynchronous reset mid-beat
    step(1'b1, 6'b100000, 3'b000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst op_valid", op_valid, 1'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst lane_en", lane_en, 16'h0000);
    chk("arst beat_idx", beat_idx, 2'd0);
    chk("arst op_last", op_last, 1'b0);
    exp_q.delete();
    exp_ill = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back subi, branch, then ALUOp=0
    step(1'b1, 6'b001001, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("subi ctrl", ALUControl, 3'b001);
    step(1'b1, 6'b000100, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("branch valid", op_valid, 1'b1);
    chk("branch ctrl", ALUControl, 3'b001);
    step(1'b1, 6'b000100, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("aluop0 valid", op_valid, 1'b1);
    chk("aluop0 ctrl", ALUControl, 3'b000);
    idle_cycle();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] opc;
      case ($urandom_range(0, 6))
        0: opc = 6'b000000;
        1: opc = 6'b100000;
        2: opc = 6'b001000;
        3: opc = 6'b001001;
        4: opc = 6'b001010;
        5: opc = 6'b000100;
        default: opc = 6'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), opc, 3'($urandom), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
